// File: rtl/ensemble_majority_voter_pkg.sv
// Shared definitions for the spiking-net ensemble voter: FSM encoding, vote counter
// width helper and the label/class defaults used by the spiking nets.
package ensemble_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_TALLY,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam int DEF_LABEL_W   = 5;
  localparam int DEF_N_CLASSES = 18;

  // A counter of this width holds any vote total from n nets.
  function automatic int vote_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ensemble_majority_voter_if.sv
// Label-capture and result bundle between the spiking nets (master) and the voter (slave).
interface ensemble_majority_voter_if
  import ensemble_pkg::*;
#(
  parameter int N_NETS  = 5,
  parameter int LABEL_W = DEF_LABEL_W
);
  localparam int VOTE_W = vote_w(N_NETS);

  logic                        trans_start;
  logic [N_NETS-1:0]           net_done;
  logic [N_NETS*LABEL_W-1:0]   net_label;
  logic [LABEL_W-1:0]          winner;
  logic [VOTE_W-1:0]           winner_votes;
  logic                        winner_tie;
  logic                        winner_valid;
  logic                        busy;
  logic                        timed_out;

  modport master (
    output trans_start, net_done, net_label,
    input  winner, winner_votes, winner_tie, winner_valid, busy, timed_out
  );

  modport slave (
    input  trans_start, net_done, net_label,
    output winner, winner_votes, winner_tie, winner_valid, busy, timed_out
  );
endinterface

// File: rtl/ensemble_majority_voter_vote_tally.sv
// Per-class vote counter array with a single increment port and a combinational read port.
module ensemble_vote_tally
  import ensemble_pkg::*;
#(
  parameter int N_CLASSES = DEF_N_CLASSES,
  parameter int LABEL_W   = DEF_LABEL_W,
  parameter int CNT_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               inc_en,
  input  logic [LABEL_W-1:0] inc_idx,
  input  logic [LABEL_W-1:0] rd_idx,
  output logic [CNT_W-1:0]   rd_cnt
);

  logic [CNT_W-1:0] cnt_all [N_CLASSES];

  for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (clear) begin
        cnt_reg <= '0;
      end else if (inc_en && inc_idx == LABEL_W'(gi)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign cnt_all[gi] = cnt_reg;
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (rd_idx == LABEL_W'(i)) rd_cnt = cnt_all[i];
    end
  end

endmodule

// File: rtl/ensemble_majority_voter.sv
// Ensemble majority voter: captures one label per net, tallies votes, scans for the argmax.
// Optional collect-phase timeout is enabled by defining ENSEMBLE_TIMEOUT_EN.
module ensemble_majority_voter
  import ensemble_pkg::*;
#(
  parameter int N_NETS      = 5,
  parameter int LABEL_W     = DEF_LABEL_W,
  parameter int N_CLASSES   = DEF_N_CLASSES,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ensemble_majority_voter_if.slave  bus
);

  localparam int VOTE_W = vote_w(N_NETS);
  localparam int IDX_W  = (N_NETS > 1) ? $clog2(N_NETS) : 1;

  state_t               state_reg;
  logic [N_NETS-1:0]    cap_vec;
  logic [LABEL_W-1:0]   label_arr [N_NETS];
  logic [IDX_W-1:0]     net_idx_reg;
  logic [LABEL_W-1:0]   cls_idx_reg;
  logic [VOTE_W-1:0]    best_cnt_reg;
  logic [LABEL_W-1:0]   best_cls_reg;
  logic                 tie_reg;
  logic [LABEL_W-1:0]   winner_reg;
  logic [VOTE_W-1:0]    votes_reg;
  logic                 winner_tie_reg;
  logic                 valid_reg;
  logic                 timeout_hit;
  logic                 timed_out_reg;
  logic [LABEL_W-1:0]   sel_label;
  logic                 sel_cap;
  logic                 inc_en;
  logic [VOTE_W-1:0]    rd_cnt;

  // First strobe per net wins; restart clears the capture flag.
  for (genvar gi = 0; gi < N_NETS; gi++) begin : g_cap
    logic               cap_reg;
    logic [LABEL_W-1:0] label_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cap_reg   <= 1'b0;
        label_reg <= '0;
      end else if (bus.trans_start) begin
        cap_reg   <= 1'b0;
      end else if (state_reg == ST_COLLECT && bus.net_done[gi] && !cap_reg) begin
        cap_reg   <= 1'b1;
        label_reg <= bus.net_label[gi*LABEL_W +: LABEL_W];
      end
    end

    assign cap_vec[gi]   = cap_reg;
    assign label_arr[gi] = label_reg;
  end

  always_comb begin
    sel_label = '0;
    sel_cap   = 1'b0;
    for (int i = 0; i < N_NETS; i++) begin
      if (net_idx_reg == IDX_W'(i)) begin
        sel_label = label_arr[i];
        sel_cap   = cap_vec[i];
      end
    end
  end

  // Extra bit so N_CLASSES == 2**LABEL_W compares correctly.
  assign inc_en = (state_reg == ST_TALLY) && sel_cap &&
                  ({1'b0, sel_label} < (LABEL_W+1)'(N_CLASSES));

  ensemble_vote_tally #(
    .N_CLASSES (N_CLASSES),
    .LABEL_W   (LABEL_W),
    .CNT_W     (VOTE_W)
  ) u_tally (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.trans_start),
    .inc_en  (inc_en),
    .inc_idx (sel_label),
    .rd_idx  (cls_idx_reg),
    .rd_cnt  (rd_cnt)
  );

`ifdef ENSEMBLE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] coll_cnt_reg;

  assign timeout_hit = (coll_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt_reg  <= '0;
      timed_out_reg <= 1'b0;
    end else if (bus.trans_start) begin
      coll_cnt_reg  <= '0;
      timed_out_reg <= 1'b0;
    end else if (state_reg == ST_COLLECT && !(&cap_vec)) begin
      if (timeout_hit) timed_out_reg <= 1'b1;
      else             coll_cnt_reg  <= coll_cnt_reg + TO_W'(1);
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit   = 1'b0;
  assign timed_out_reg = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      net_idx_reg    <= '0;
      cls_idx_reg    <= '0;
      best_cnt_reg   <= '0;
      best_cls_reg   <= '0;
      tie_reg        <= 1'b0;
      winner_reg     <= '0;
      votes_reg      <= '0;
      winner_tie_reg <= 1'b0;
      valid_reg      <= 1'b0;
    end else if (bus.trans_start) begin
      state_reg      <= ST_COLLECT;
      net_idx_reg    <= '0;
      cls_idx_reg    <= '0;
      best_cnt_reg   <= '0;
      best_cls_reg   <= '0;
      tie_reg        <= 1'b0;
      winner_reg     <= '0;
      votes_reg      <= '0;
      winner_tie_reg <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: valid_reg <= 1'b0;
        ST_COLLECT: begin
          if ((&cap_vec) || timeout_hit) state_reg <= ST_TALLY;
        end
        ST_TALLY: begin
          if (net_idx_reg == IDX_W'(N_NETS - 1)) state_reg <= ST_SCAN;
          else net_idx_reg <= net_idx_reg + IDX_W'(1);
        end
        ST_SCAN: begin
          // Strictly greater replaces, so the lowest class index wins a tie.
          if (rd_cnt > best_cnt_reg) begin
            best_cnt_reg <= rd_cnt;
            best_cls_reg <= cls_idx_reg;
            tie_reg      <= 1'b0;
          end else if (rd_cnt == best_cnt_reg && best_cnt_reg != '0) begin
            tie_reg      <= 1'b1;
          end
          if (cls_idx_reg == LABEL_W'(N_CLASSES - 1)) state_reg <= ST_DONE;
          else cls_idx_reg <= cls_idx_reg + LABEL_W'(1);
        end
        ST_DONE: begin
          winner_reg     <= best_cls_reg;
          votes_reg      <= best_cnt_reg;
          winner_tie_reg <= tie_reg;
          valid_reg      <= 1'b1;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.winner       = winner_reg;
  assign bus.winner_votes = votes_reg;
  assign bus.winner_tie   = winner_tie_reg;
  assign bus.winner_valid = valid_reg;
  assign bus.timed_out    = timed_out_reg;
  assign bus.busy         = (state_reg == ST_COLLECT) || (state_reg == ST_TALLY) ||
                            (state_reg == ST_SCAN);

endmodule

// File: tb/tb_ensemble_majority_voter.sv
// Directed-vector bench for ensemble_majority_voter; behaviour of the timeout case
// follows whether ENSEMBLE_TIMEOUT_EN is defined.
module tb_ensemble_majority_voter;
  import ensemble_pkg::*;

  localparam int N_NETS      = 5;
  localparam int LABEL_W     = 5;
  localparam int N_CLASSES   = 18;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ensemble_majority_voter_if #(.N_NETS(N_NETS), .LABEL_W(LABEL_W)) bus ();

  ensemble_majority_voter #(
    .N_NETS      (N_NETS),
    .LABEL_W     (LABEL_W),
    .N_CLASSES   (N_CLASSES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] pack5(input int l0, input int l1, input int l2,
                                        input int l3, input int l4);
    return {5'(l4), 5'(l3), 5'(l2), 5'(l1), 5'(l0)};
  endfunction

  task automatic start_txn();
    @(negedge clk);
    bus.trans_start = 1'b1;
    @(negedge clk);
    bus.trans_start = 1'b0;
  endtask

  task automatic strobe(input logic [4:0] mask, input logic [24:0] labels);
    @(negedge clk);
    bus.net_done  = mask;
    bus.net_label = labels;
    @(negedge clk);
    bus.net_done  = '0;
  endtask

  // Called on the negedge right after the last capture edge.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.winner_valid !== 1'b1 && n < 200);
    check({tag, ".valid"}, 32'(bus.winner_valid), 32'd1);
    if (exp_lat > 0) check({tag, ".latency"}, n, exp_lat);
  endtask

  task automatic check_result(input string tag, input int w, input int v, input int t);
    $display("txn %s: winner=%0d votes=%0d tie=%0d timed_out=%0d", tag,
             bus.winner, bus.winner_votes, bus.winner_tie, bus.timed_out);
    check({tag, ".winner"}, 32'(bus.winner), w);
    check({tag, ".votes"},  32'(bus.winner_votes), v);
    check({tag, ".tie"},    32'(bus.winner_tie), t);
    @(negedge clk);
    check({tag, ".pulse"},  32'(bus.winner_valid), 32'd0);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.winner_valid === 1'b1) seen++;
    end
  endtask

  initial begin
    int seen;
    bus.trans_start = 1'b0;
    bus.net_done    = '0;
    bus.net_label   = '0;

    repeat (3) @(negedge clk);
    check("rst.winner",    32'(bus.winner), 0);
    check("rst.votes",     32'(bus.winner_votes), 0);
    check("rst.tie",       32'(bus.winner_tie), 0);
    check("rst.valid",     32'(bus.winner_valid), 0);
    check("rst.busy",      32'(bus.busy), 0);
    check("rst.timed_out", 32'(bus.timed_out), 0);
    rst_n = 1'b1;

    // 1: all nets at once
    start_txn();
    check("t1.busy", 32'(bus.busy), 1);
    strobe(5'b11111, pack5(3, 3, 7, 3, 9));
    wait_valid("t1", 25);
    check_result("t1", 3, 3, 0);
    check("t1.timed_out", 32'(bus.timed_out), 0);
    check("t1.idle_busy", 32'(bus.busy), 0);

    // 2: staggered, tie between 2 and 5
    start_txn();
    for (int i = 0; i < N_NETS; i++) strobe(5'(1 << i), pack5(2, 5, 2, 5, 1));
    wait_valid("t2", 25);
    check_result("t2", 2, 2, 1);

    // 3: out-of-range labels abstain
    start_txn();
    strobe(5'b11111, pack5(20, 31, 4, 4, 25));
    wait_valid("t3", 25);
    check_result("t3", 4, 2, 0);

    // 3b: every vote abstains
    start_txn();
    strobe(5'b11111, pack5(31, 18, 25, 30, 19));
    wait_valid("t3b", 25);
    check_result("t3b", 0, 0, 0);

    // 4: net 1 strobes twice, first label must stick
    start_txn();
    strobe(5'b00010, pack5(0, 6, 0, 0, 0));
    strobe(5'b00010, pack5(0, 8, 0, 0, 0));
    strobe(5'b11101, pack5(6, 8, 8, 8, 6));
    wait_valid("t4", 25);
    check_result("t4", 6, 3, 0);

    // net_done in IDLE is ignored and results hold
    strobe(5'b11111, pack5(0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    check("idle.busy",   32'(bus.busy), 0);
    check("idle.winner", 32'(bus.winner), 6);
    check("idle.votes",  32'(bus.winner_votes), 3);

    // 5: restart mid-TALLY
    start_txn();
    strobe(5'b11111, pack5(1, 1, 1, 2, 2));
    repeat (2) @(negedge clk);
    start_txn();
    check("t5.busy",   32'(bus.busy), 1);
    check("t5.winner", 32'(bus.winner), 0);
    strobe(5'b11111, pack5(11, 11, 11, 11, 11));
    wait_valid("t5", 25);
    check_result("t5", 11, 5, 0);
    count_valid(40, seen);
    check("t5.extra_valid", seen, 0);

    // 5b: restart wins over net_done in the same cycle
    @(negedge clk);
    bus.trans_start = 1'b1;
    bus.net_done    = 5'b11111;
    bus.net_label   = pack5(4, 4, 4, 4, 4);
    @(negedge clk);
    bus.trans_start = 1'b0;
    bus.net_done    = '0;
    repeat (3) @(negedge clk);
    check("t5b.busy", 32'(bus.busy), 1);
    strobe(5'b11111, pack5(13, 13, 13, 13, 13));
    wait_valid("t5b", 25);
    check_result("t5b", 13, 5, 0);

    // reset in the middle of a transaction
    start_txn();
    strobe(5'b11111, pack5(3, 3, 3, 3, 3));
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.busy",  32'(bus.busy), 0);
    check("rstmid.valid", 32'(bus.winner_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(40, seen);
    check("rstmid.no_valid", seen, 0);
    check("rstmid.winner", 32'(bus.winner), 0);

    // 6: only nets 0 and 2 report
    start_txn();
    strobe(5'b00101, pack5(9, 0, 9, 0, 0));
`ifdef ENSEMBLE_TIMEOUT_EN
    wait_valid("t6", 0);
    check("t6.timed_out", 32'(bus.timed_out), 1);
    check_result("t6", 9, 2, 0);
    check("t6.busy", 32'(bus.busy), 0);
`else
    count_valid(100, seen);
    check("t6.no_valid",  seen, 0);
    check("t6.busy",      32'(bus.busy), 1);
    check("t6.timed_out", 32'(bus.timed_out), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
